// File: rtl/fe_req_pkg.sv
// ----------------------------------------------------------------------------
// fe_req_pkg
// Shared definitions for the front-end request controller: Avalon-MM register
// word offsets and the width of the edge counter.
// ----------------------------------------------------------------------------
package fe_req_pkg;

    // Register word offsets on the 2-bit slave address.
    typedef enum logic [1:0] {
        RegLevel   = 2'd0,
        RegPending = 2'd1,
        RegMask    = 2'd2,
        RegEdgecnt = 2'd3
    } reg_addr_e;

    localparam int unsigned EDGECNT_W = 16;

endpackage

// File: rtl/sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for one asynchronous level input.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset, clears every stage
//   i_d    - asynchronous input level
//   o_q    - synchronized level (last stage of the chain)
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/fe_req_ctl.sv
// ----------------------------------------------------------------------------
// fe_req_ctl
// Synchronizes N asynchronous device request lines, latches their rising
// edges into a W1C pending register, counts edge cycles and raises a masked
// level interrupt. Registers are reachable over an Avalon-MM slave with a
// fixed read latency of one cycle.
// Ports:
//   clk          - 50 MHz fabric clock
//   reset        - asynchronous active-high reset
//   req_in       - device request levels, asynchronous to clk
//   s_address    - slave word address (0 LEVEL, 1 PENDING, 2 MASK, 3 EDGECNT)
//   s_read       - read strobe
//   s_write      - write strobe
//   s_writedata  - write data
//   s_readdata   - registered read data, held until the next read
//   irq          - registered OR of PENDING & MASK
//   level        - synchronized request levels
// ----------------------------------------------------------------------------
module fe_req_ctl
    import fe_req_pkg::*;
#(
    parameter int N           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_in,
    input  logic [1:0]    s_address,
    input  logic          s_read,
    input  logic          s_write,
    input  logic [31:0]   s_writedata,
    output logic [31:0]   s_readdata,
    output logic          irq,
    output logic [N-1:0]  level
);

    localparam logic [EDGECNT_W-1:0] EdgecntOne = 1;

    logic [N-1:0]           w_level;
    logic [N-1:0]           w_rise;
    logic [N-1:0]           w_w1c;
    logic                   w_wr_mask;
    logic                   w_wr_cnt;
    logic [31:0]            w_rdata;

    logic [N-1:0]           r_prev;
    logic [N-1:0]           r_pending;
    logic [N-1:0]           r_mask;
    logic [EDGECNT_W-1:0]   r_edgecnt;
    logic [31:0]            r_readdata;
    logic                   r_irq;

    for (genvar gi = 0; gi < N; gi++) begin : g_sync
        sync_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .i_d   (req_in[gi]),
            .o_q   (w_level[gi])
        );
    end

    assign w_rise    = w_level & ~r_prev;
    assign w_w1c     = (s_write && (s_address == RegPending)) ? s_writedata[N-1:0] : '0;
    assign w_wr_mask = s_write && (s_address == RegMask);
    assign w_wr_cnt  = s_write && (s_address == RegEdgecnt);

    // Read mux works on pre-update state so a read in the same cycle as a
    // write or an edge returns the old value.
    always_comb begin
        w_rdata = '0;
        unique case (reg_addr_e'(s_address))
            RegLevel:   w_rdata[N-1:0]         = w_level;
            RegPending: w_rdata[N-1:0]         = r_pending;
            RegMask:    w_rdata[N-1:0]         = r_mask;
            RegEdgecnt: w_rdata[EDGECNT_W-1:0] = r_edgecnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_edgecnt  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev    <= w_level;
            // Clear first, then set: a new edge wins over a same-cycle W1C.
            r_pending <= (r_pending & ~w_w1c) | w_rise;
            if (w_wr_mask) begin
                r_mask <= s_writedata[N-1:0];
            end
            // Clear wins over a coincident increment; wraps naturally.
            if (w_wr_cnt) begin
                r_edgecnt <= '0;
            end else if (|w_rise) begin
                r_edgecnt <= r_edgecnt + EdgecntOne;
            end
            if (s_read) begin
                r_readdata <= w_rdata;
            end
            r_irq <= |(r_pending & r_mask);
        end
    end

    assign s_readdata = r_readdata;
    assign irq        = r_irq;
    assign level      = w_level;

endmodule
